ddr2_idelay_seq: RTL and testbench

Sequencer for the DDR2 input-delay calibration resources in the clk200 domain. It drives the IDELAYCTRL reset and waits for its RDY. It then resets all variable IODELAY taps and steps individual delay groups to requested tap values using CE/INC pulses, reporting completion through a req/ack handshake. If RDY is lost or never arrives, it re-runs the IDELAYCTRL bring-up and flags the fault to the calibration logic.

---
 rtl/ddr2_idelay_seq_if.sv | 28 ++
 rtl/ddr2_idelay_seq.sv | 173 +++++++++++++++++
 tb/tb_ddr2_idelay_seq.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr2_idelay_seq_if.sv
// Tap-change request channel between the DDR2 calibration logic (master)
// and the IODELAY sequencer (slave).
interface ddr2_idelay_seq_if #(
  parameter int unsigned GRP_W = 2,
  parameter int unsigned TAP_W = 6
) ();
  logic             tap_req;
  logic [GRP_W-1:0] tap_grp;
  logic [TAP_W-1:0] tap_val;
  logic             tap_ack;
  logic             ctrl_ready;

  modport master (
    output tap_req,
    output tap_grp,
    output tap_val,
    input  tap_ack,
    input  ctrl_ready
  );

  modport slave (
    input  tap_req,
    input  tap_grp,
    input  tap_val,
    output tap_ack,
    output ctrl_ready
  );
endinterface

// File: rtl/ddr2_idelay_seq.sv
// DDR2 input-delay sequencer (clk200 domain). Brings up IDELAYCTRL, clears
// all IODELAY taps, then walks one delay group at a time to a requested tap
// with single CE/INC pulses separated by an idle cycle. Loss or absence of
// RDY restarts the bring-up and is reported through retry_cnt/timeout_err.
module ddr2_idelay_seq #(
  parameter int unsigned RST_CYCLES  = 16,
  parameter int unsigned RDY_TIMEOUT = 4096,
  parameter int unsigned N_GRP       = 4,
  parameter int unsigned GRP_W       = 2,
  parameter int unsigned TAP_W       = 6
) (
  input  logic             clk200,
  input  logic             rst200,
  input  logic             idelay_ctrl_rdy,
  output logic             idelayctrl_rst,
  output logic             iodelay_rst,
  output logic [N_GRP-1:0] iodelay_ce,
  output logic             iodelay_inc,
  ddr2_idelay_seq_if.slave tap_if,
  output logic             timeout_err,
  output logic [3:0]       retry_cnt
);

  localparam int unsigned CNT_MAX = (RDY_TIMEOUT > RST_CYCLES) ? RDY_TIMEOUT : RST_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [2:0] S_RST_ASSERT = 3'd0;
  localparam logic [2:0] S_WAIT_RDY   = 3'd1;
  localparam logic [2:0] S_TAP_RESET  = 3'd2;
  localparam logic [2:0] S_IDLE       = 3'd3;
  localparam logic [2:0] S_STEP       = 3'd4;
  localparam logic [2:0] S_GAP        = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;

  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             rdy_meta_p0, rdy_sync_p1;
  logic             rdy_lost;
  logic             timeout_hit;
  logic             retry_inc;
  logic             req_grp_ok;
  logic             step_up;
  logic [GRP_W-1:0] grp_q;
  logic [TAP_W-1:0] val_q;
  logic [TAP_W-1:0] cur [N_GRP];
  logic [TAP_W-1:0] cur_req;
  logic [TAP_W-1:0] cur_sel;

  // Saturating bring-up retry counter increment.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Two-flop synchronizer for the asynchronous IDELAYCTRL RDY.
  always_ff @(posedge clk200 or posedge rst200) begin
    if (rst200) begin
      rdy_meta_p0 <= 1'b0;
      rdy_sync_p1 <= 1'b0;
    end else begin
      rdy_meta_p0 <= idelay_ctrl_rdy;
      rdy_sync_p1 <= rdy_meta_p0;
    end
  end

  // Current tap of the group being requested and of the latched group.
  always_comb begin
    cur_req = '0;
    cur_sel = '0;
    for (int unsigned g = 0; g < N_GRP; g++) begin
      if (tap_if.tap_grp == GRP_W'(g)) cur_req = cur[g];
      if (grp_q == GRP_W'(g))          cur_sel = cur[g];
    end
  end

  assign req_grp_ok = 32'(tap_if.tap_grp) < N_GRP;
  assign step_up    = val_q > cur_sel;
  assign rdy_lost   = !rdy_sync_p1 &&
                      (state inside {S_TAP_RESET, S_IDLE, S_STEP, S_GAP, S_DONE});

  // Next-state, cycle counter and fault event decode.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    timeout_hit = 1'b0;
    retry_inc   = 1'b0;
    case (state)
      S_RST_ASSERT: begin
        if (cnt == CNT_W'(RST_CYCLES - 1)) begin
          state_nx = S_WAIT_RDY;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_WAIT_RDY: begin
        if (rdy_sync_p1) begin
          state_nx = S_TAP_RESET;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(RDY_TIMEOUT - 1)) begin
          state_nx    = S_RST_ASSERT;
          cnt_nx      = '0;
          timeout_hit = 1'b1;
          retry_inc   = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_TAP_RESET: state_nx = S_IDLE;
      S_IDLE: begin
        if (tap_if.tap_req)
          state_nx = (!req_grp_ok || (tap_if.tap_val == cur_req)) ? S_DONE : S_STEP;
      end
      S_STEP: state_nx = S_GAP;
      S_GAP:  state_nx = (cur_sel == val_q) ? S_DONE : S_STEP;
      S_DONE: state_nx = S_IDLE;
      default: begin
        state_nx = S_RST_ASSERT;
        cnt_nx   = '0;
      end
    endcase
    // Losing RDY anywhere past bring-up restarts the whole sequence.
    if (rdy_lost) begin
      state_nx  = S_RST_ASSERT;
      cnt_nx    = '0;
      retry_inc = 1'b1;
    end
  end

  // Control state: FSM, counter, sticky timeout flag, retry count.
  always_ff @(posedge clk200 or posedge rst200) begin
    if (rst200) begin
      state       <= S_RST_ASSERT;
      cnt         <= '0;
      timeout_err <= 1'b0;
      retry_cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (timeout_hit) timeout_err <= 1'b1;
      if (retry_inc)   retry_cnt   <= sat_inc(retry_cnt);
    end
  end

  // Request latch and per-group tap shadow; TAP_RESET always precedes use.
  always_ff @(posedge clk200) begin
    if (state == S_IDLE && tap_if.tap_req) begin
      grp_q <= tap_if.tap_grp;
      val_q <= tap_if.tap_val;
    end
    for (int unsigned g = 0; g < N_GRP; g++) begin
      if (state == S_TAP_RESET)
        cur[g] <= '0;
      else if (state == S_STEP && grp_q == GRP_W'(g))
        cur[g] <= step_up ? cur[g] + TAP_W'(1) : cur[g] - TAP_W'(1);
    end
  end

  // One-hot CE for the latched group, only during STEP.
  always_comb begin
    iodelay_ce = '0;
    if (state == S_STEP) begin
      for (int unsigned g = 0; g < N_GRP; g++)
        if (grp_q == GRP_W'(g)) iodelay_ce[g] = 1'b1;
    end
  end

  assign idelayctrl_rst    = (state == S_RST_ASSERT);
  assign iodelay_rst       = (state == S_TAP_RESET);
  assign iodelay_inc       = (state == S_STEP) && step_up;
  assign tap_if.ctrl_ready = (state == S_IDLE);
  assign tap_if.tap_ack    = (state == S_DONE);

endmodule

// File: tb/tb_ddr2_idelay_seq.sv
// Testbench for ddr2_idelay_seq: directed bring-up/fault scenarios plus
// randomized tap requests checked against a per-group tap model.
module tb_ddr2_idelay_seq;

  localparam int N_GRP       = 4;
  localparam int GRP_W       = 3;
  localparam int TAP_W       = 6;
  localparam int RST_CYCLES  = 16;
  localparam int RDY_TIMEOUT = 4096;
  localparam int PERIOD_TO   = RST_CYCLES + RDY_TIMEOUT;

  logic             clk200 = 1'b0;
  logic             rst200 = 1'b1;
  logic             idelay_ctrl_rdy = 1'b0;
  logic             idelayctrl_rst;
  logic             iodelay_rst;
  logic [N_GRP-1:0] iodelay_ce;
  logic             iodelay_inc;
  logic             timeout_err;
  logic [3:0]       retry_cnt;

  int checks = 0;
  int errors = 0;
  int model_tap [N_GRP];
  int model_retry = 0;

  ddr2_idelay_seq_if #(.GRP_W(GRP_W), .TAP_W(TAP_W)) tif ();

  ddr2_idelay_seq #(
    .RST_CYCLES (RST_CYCLES),
    .RDY_TIMEOUT(RDY_TIMEOUT),
    .N_GRP      (N_GRP),
    .GRP_W      (GRP_W),
    .TAP_W      (TAP_W)
  ) dut (
    .clk200         (clk200),
    .rst200         (rst200),
    .idelay_ctrl_rdy(idelay_ctrl_rdy),
    .idelayctrl_rst (idelayctrl_rst),
    .iodelay_rst    (iodelay_rst),
    .iodelay_ce     (iodelay_ce),
    .iodelay_inc    (iodelay_inc),
    .tap_if         (tif),
    .timeout_err    (timeout_err),
    .retry_cnt      (retry_cnt)
  );

  always #5 clk200 = ~clk200;

  task automatic tick();
    @(negedge clk200);
  endtask

  task automatic clear_model_taps();
    for (int g = 0; g < N_GRP; g++) model_tap[g] = 0;
  endtask

  task automatic test_reset();
    rst200 = 1'b1;
    idelay_ctrl_rdy = 1'b0;
    tif.tap_req = 1'b0;
    tif.tap_grp = '0;
    tif.tap_val = '0;
    repeat (3) tick();
    checks++;
    if (idelayctrl_rst !== 1'b1) begin
      errors++; $display("FAIL reset_idelayctrl_rst got %b expected 1", idelayctrl_rst);
    end
    checks++;
    if (iodelay_rst !== 1'b0 || iodelay_ce !== '0 || iodelay_inc !== 1'b0) begin
      errors++; $display("FAIL reset_iodelay got rst=%b ce=%b inc=%b expected 0", iodelay_rst, iodelay_ce, iodelay_inc);
    end
    checks++;
    if (tif.tap_ack !== 1'b0 || tif.ctrl_ready !== 1'b0) begin
      errors++; $display("FAIL reset_handshake got ack=%b ready=%b expected 0", tif.tap_ack, tif.ctrl_ready);
    end
    checks++;
    if (timeout_err !== 1'b0 || retry_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_fault got to=%b retry=%0d expected 0", timeout_err, retry_cnt);
    end
  endtask

  // Release reset at cycle 0, raise RDY at cycle 30.
  task automatic test_bringup();
    rst200 = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      checks++;
      if (idelayctrl_rst !== (k < RST_CYCLES)) begin
        errors++; $display("FAIL bringup_idelayctrl_rst k=%0d got %b expected %b", k, idelayctrl_rst, k < RST_CYCLES);
      end
      checks++;
      if (iodelay_rst !== (k == 33)) begin
        errors++; $display("FAIL bringup_iodelay_rst k=%0d got %b expected %b", k, iodelay_rst, k == 33);
      end
      checks++;
      if (tif.ctrl_ready !== (k >= 34)) begin
        errors++; $display("FAIL bringup_ready k=%0d got %b expected %b", k, tif.ctrl_ready, k >= 34);
      end
      if (k == 30) idelay_ctrl_rdy = 1'b1;
      if (k < 40) tick();
    end
    checks++;
    if (timeout_err !== 1'b0 || retry_cnt !== 4'd0) begin
      errors++; $display("FAIL bringup_fault got to=%b retry=%0d expected 0", timeout_err, retry_cnt);
    end
    clear_model_taps();
    model_retry = 0;
  endtask

  // One request from acceptance through ctrl_ready returning. With hold set,
  // tap_req stays high with junk grp/val while busy; it must be ignored.
  task automatic run_req(input int grp, input int val, input bit hold);
    int w;
    int d;
    bit up;
    bit g_ok;
    logic [N_GRP-1:0] exp_ce;
    w = 0;
    while (tif.ctrl_ready !== 1'b1 && w < 300) begin
      tick();
      w++;
    end
    checks++;
    if (tif.ctrl_ready !== 1'b1) begin
      errors++; $display("FAIL req_wait_ready got %b expected 1", tif.ctrl_ready);
      return;
    end
    g_ok = (grp < N_GRP);
    d = 0;
    up = 1'b0;
    if (g_ok) begin
      d = (val > model_tap[grp]) ? val - model_tap[grp] : model_tap[grp] - val;
      up = (val > model_tap[grp]);
    end
    tif.tap_req = 1'b1;
    tif.tap_grp = GRP_W'(grp);
    tif.tap_val = TAP_W'(val);
    for (int k = 1; k <= 2 * d + 2; k++) begin
      tick();
      exp_ce = '0;
      if ((k % 2 == 1) && (k <= 2 * d - 1)) exp_ce[grp] = 1'b1;
      checks++;
      if (iodelay_ce !== exp_ce) begin
        errors++; $display("FAIL req_ce grp=%0d val=%0d k=%0d got %b expected %b", grp, val, k, iodelay_ce, exp_ce);
      end
      if (exp_ce != '0) begin
        checks++;
        if (iodelay_inc !== up) begin
          errors++; $display("FAIL req_inc grp=%0d val=%0d k=%0d got %b expected %b", grp, val, k, iodelay_inc, up);
        end
      end
      checks++;
      if (tif.tap_ack !== (k == 2 * d + 1)) begin
        errors++; $display("FAIL req_ack grp=%0d val=%0d k=%0d got %b expected %b", grp, val, k, tif.tap_ack, k == 2 * d + 1);
      end
      checks++;
      if (tif.ctrl_ready !== (k == 2 * d + 2)) begin
        errors++; $display("FAIL req_ready grp=%0d val=%0d k=%0d got %b expected %b", grp, val, k, tif.ctrl_ready, k == 2 * d + 2);
      end
      if (hold && k < 2 * d + 1) begin
        tif.tap_req = 1'b1;
        tif.tap_grp = GRP_W'($urandom_range(0, 7));
        tif.tap_val = TAP_W'($urandom_range(0, 63));
      end else begin
        tif.tap_req = 1'b0;
      end
    end
    if (g_ok) model_tap[grp] = val;
  endtask

  task automatic test_increment();
    run_req(1, 5, 1'b0);
  endtask

  task automatic test_decrement_noop();
    run_req(1, 2, 1'b0);
    run_req(1, 2, 1'b1);
    run_req(5, 17, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_req(0, 63, 1'b0);
    run_req(0, 0, 1'b1);
    run_req(3, 1, 1'b0);
    run_req(2, 40, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      run_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
  endtask

  // Drop RDY in the third STEP of a 0->10 walk on group 2.
  task automatic test_rdy_loss();
    logic [N_GRP-1:0] exp_ce;
    run_req(2, 0, 1'b0);
    tif.tap_req = 1'b1;
    tif.tap_grp = GRP_W'(2);
    tif.tap_val = TAP_W'(10);
    for (int k = 1; k <= 26; k++) begin
      tick();
      exp_ce = '0;
      if ((k % 2 == 1) && (k <= 7)) exp_ce[2] = 1'b1;
      checks++;
      if (iodelay_ce !== exp_ce) begin
        errors++; $display("FAIL loss_ce k=%0d got %b expected %b", k, iodelay_ce, exp_ce);
      end
      checks++;
      if (tif.tap_ack !== 1'b0) begin
        errors++; $display("FAIL loss_ack k=%0d got %b expected 0", k, tif.tap_ack);
      end
      checks++;
      if (idelayctrl_rst !== (k >= 8 && k < 8 + RST_CYCLES)) begin
        errors++; $display("FAIL loss_idelayctrl_rst k=%0d got %b expected %b", k, idelayctrl_rst, k >= 8 && k < 8 + RST_CYCLES);
      end
      checks++;
      if (iodelay_rst !== (k == 25)) begin
        errors++; $display("FAIL loss_iodelay_rst k=%0d got %b expected %b", k, iodelay_rst, k == 25);
      end
      checks++;
      if (tif.ctrl_ready !== (k == 26)) begin
        errors++; $display("FAIL loss_ready k=%0d got %b expected %b", k, tif.ctrl_ready, k == 26);
      end
      if (k == 8) begin
        checks++;
        if (retry_cnt !== 4'(model_retry + 1)) begin
          errors++; $display("FAIL loss_retry got %0d expected %0d", retry_cnt, model_retry + 1);
        end
      end
      if (k == 1) tif.tap_req = 1'b0;
      if (k == 5) idelay_ctrl_rdy = 1'b0;
      if (k == 10) idelay_ctrl_rdy = 1'b1;
    end
    model_retry++;
    clear_model_taps();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL loss_timeout_err got %b expected 0", timeout_err);
    end
    run_req(2, 10, 1'b0);
  endtask

  // RDY held low from reset release: a timeout every RST_CYCLES+RDY_TIMEOUT.
  task automatic test_timeout();
    int cyc;
    rst200 = 1'b1;
    idelay_ctrl_rdy = 1'b0;
    repeat (2) tick();
    rst200 = 1'b0;
    model_retry = 0;
    cyc = 0;
    for (int n = 1; n <= 16; n++) begin
      while (cyc < n * PERIOD_TO - 1) begin
        tick();
        cyc++;
      end
      checks++;
      if (timeout_err !== (n > 1) || idelayctrl_rst !== 1'b0) begin
        errors++; $display("FAIL timeout_before n=%0d got to=%b rst=%b expected to=%b rst=0", n, timeout_err, idelayctrl_rst, n > 1);
      end
      tick();
      cyc++;
      model_retry = (model_retry < 15) ? model_retry + 1 : 15;
      checks++;
      if (timeout_err !== 1'b1 || idelayctrl_rst !== 1'b1) begin
        errors++; $display("FAIL timeout_hit n=%0d got to=%b rst=%b expected to=1 rst=1", n, timeout_err, idelayctrl_rst);
      end
      checks++;
      if (retry_cnt !== 4'(model_retry)) begin
        errors++; $display("FAIL timeout_retry n=%0d got %0d expected %0d", n, retry_cnt, model_retry);
      end
    end
    idelay_ctrl_rdy = 1'b1;
    clear_model_taps();
    run_req(0, 3, 1'b0);
  endtask

  // rst200 raised in the middle of a STEP cycle.
  task automatic test_async_reset();
    int w;
    w = 0;
    while (tif.ctrl_ready !== 1'b1 && w < 300) begin
      tick();
      w++;
    end
    tif.tap_req = 1'b1;
    tif.tap_grp = GRP_W'(3);
    tif.tap_val = TAP_W'(40);
    tick();
    tif.tap_req = 1'b0;
    checks++;
    if (iodelay_ce !== 4'b1000 || retry_cnt !== 4'd15 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL areset_pre got ce=%b retry=%0d to=%b expected ce=1000 retry=15 to=1", iodelay_ce, retry_cnt, timeout_err);
    end
    #2;
    rst200 = 1'b1;
    #1;
    checks++;
    if (iodelay_ce !== '0 || iodelay_inc !== 1'b0 || iodelay_rst !== 1'b0) begin
      errors++; $display("FAIL areset_iodelay got ce=%b inc=%b rst=%b expected 0", iodelay_ce, iodelay_inc, iodelay_rst);
    end
    checks++;
    if (idelayctrl_rst !== 1'b1) begin
      errors++; $display("FAIL areset_idelayctrl_rst got %b expected 1", idelayctrl_rst);
    end
    checks++;
    if (retry_cnt !== 4'd0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL areset_fault got retry=%0d to=%b expected 0", retry_cnt, timeout_err);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (tif.tap_ack !== 1'b0 || tif.ctrl_ready !== 1'b0) begin
        errors++; $display("FAIL areset_handshake k=%0d got ack=%b ready=%b expected 0", k, tif.tap_ack, tif.ctrl_ready);
      end
    end
  endtask

  initial begin
    clear_model_taps();
    test_reset();
    test_bringup();
    test_increment();
    test_decrement_noop();
    test_back_to_back();
    test_random();
    test_rdy_loss();
    test_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
